// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and FSM state encoding for irq_ctrl
package irq_ctrl_pkg;

  localparam int NDEV = 8;
  localparam int VECW = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_WAIT  = 3'd2,
    S_HELD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/irq_ctrl_prio_pick.sv
// rtl/irq_ctrl_prio_pick.sv - winner select; fixed priority (bit 0 highest) or round-robin under IRQ_ROTATE_EN
import irq_ctrl_pkg::*;

module irq_prio_pick (
  input  logic [NDEV-1:0] eligible,
`ifdef IRQ_ROTATE_EN
  input  logic [VECW-1:0] ptr,
`endif
  output logic [VECW-1:0] idx,
  output logic            any
);

`ifdef IRQ_ROTATE_EN
  logic [VECW-1:0] j;

  // Walk farthest-to-nearest from ptr+1 so the last hit is the closest one after ptr.
  always_comb begin
    idx = '0;
    j   = '0;
    any = |eligible;
    for (int k = NDEV - 1; k >= 0; k--) begin
      j = ptr + VECW'(k) + 3'd1;
      if (eligible[j]) idx = j;
    end
  end
`else
  always_comb begin
    idx = '0;
    any = |eligible;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if (eligible[k]) idx = VECW'(k);
    end
  end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - multi-source interrupt controller; IRQ_ROTATE_EN selects round-robin priority
import irq_ctrl_pkg::*;

module irq_ctrl #(
  parameter int IRQ_PULSE = 2
) (
  input  logic            clk4,
  input  logic            reset,
  input  logic [NDEV-1:0] nirq_dev,
  input  logic            nirqs,
  input  logic            nwr_mask,
  input  logic [NDEV-1:0] d_in,
  input  logic            nrd_vec,
  output logic            nirq,
  output logic [VECW-1:0] vec,
  output logic            vec_valid,
  output logic            spur,
  output logic [NDEV-1:0] pending,
  output logic [NDEV-1:0] mask
);

  logic [NDEV-1:0] sync1, sync2, sync3;
  logic [NDEV-1:0] fall, eligible, clr;
  logic [VECW-1:0] idx;
  logic            any;
  logic [3:0]      cnt;
  state_t          state, state_nx;
  logic            load_cnt, capture, ack;

  // sync3 is the previous synchronised sample; a 1->0 step marks a new request.
  assign fall     = sync3 & ~sync2;
  assign eligible = pending & mask;
  assign clr      = (capture && any) ? (NDEV'(1) << idx) : '0;

`ifdef IRQ_ROTATE_EN
  logic [VECW-1:0] ptr;

  irq_prio_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .idx      (idx),
    .any      (any)
  );

  always_ff @(posedge clk4) begin
    if (reset)                ptr <= 3'd7;
    else if (capture && any)  ptr <= idx;
  end
`else
  irq_prio_pick u_pick (
    .eligible (eligible),
    .idx      (idx),
    .any      (any)
  );
`endif

  always_ff @(posedge clk4) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_cnt = 1'b0;
    capture  = 1'b0;
    ack      = 1'b0;
    case (state)
      S_IDLE:  if (|eligible) begin state_nx = S_PULSE; load_cnt = 1'b1; end
      S_PULSE: if (cnt == 4'd1) state_nx = S_WAIT;
      S_WAIT:  if (!nirqs) begin state_nx = S_HELD; capture = 1'b1; end
      S_HELD:  if (!nrd_vec) begin state_nx = S_DRAIN; ack = 1'b1; end
      S_DRAIN: if (nirqs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk4) begin
    if (reset) begin
      sync1     <= '1;
      sync2     <= '1;
      sync3     <= '1;
      pending   <= '0;
      mask      <= '0;
      nirq      <= 1'b1;
      cnt       <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      spur      <= 1'b0;
    end else begin
      sync1   <= nirq_dev;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= (pending & ~clr) | fall;
      if (!nwr_mask) mask <= d_in;

      if (load_cnt) begin
        cnt  <= 4'(IRQ_PULSE);
        nirq <= 1'b0;
      end else if (state == S_PULSE) begin
        if (cnt == 4'd1) begin
          cnt  <= '0;
          nirq <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end

      if (capture) begin
        vec_valid <= 1'b1;
        vec       <= any ? idx : '0;
        spur      <= ~any;
      end else if (ack) begin
        vec_valid <= 1'b0;
        spur      <= 1'b0;
      end
    end
  end

endmodule
